// File: rtl/read_strided.sv
// Strided 2-D read engine: walks iterations x reads-per-iteration over a fixed-latency
// memory port and forwards returned data through a credit-protected output FIFO.
module read_strided #(
   parameter int DATA_WIDTH             = 8,
   parameter int LOG_MAX_ITERS          = 8,
   parameter int LOG_MAX_READS_PER_ITER = 16,
   parameter int LOG_MAX_ADDRESS        = 12,
   parameter int READ_LATENCY           = 1,
   parameter int FIFO_DEPTH             = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              configure,
   input  logic [LOG_MAX_ITERS-1:0]          num_iters,
   input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
   input  logic [LOG_MAX_ADDRESS-1:0]        base_address,
   input  logic [LOG_MAX_ADDRESS-1:0]        iter_stride,
   output logic [LOG_MAX_ADDRESS-1:0]        address_out,
   output logic                              request,
   input  logic                              valid_in,
   input  logic [DATA_WIDTH-1:0]             data_in,
   input  logic                              avail_in,
   output logic                              valid_out,
   output logic [DATA_WIDTH-1:0]             data_out,
   output logic                              busy,
   output logic                              done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

   state_t                              state, state_next;
   logic [LOG_MAX_ITERS-1:0]            cfg_iters;
   logic [LOG_MAX_READS_PER_ITER-1:0]   cfg_reads;
   logic [LOG_MAX_ADDRESS-1:0]          cfg_stride;
   logic [LOG_MAX_ADDRESS-1:0]          iter_base;
   logic [LOG_MAX_READS_PER_ITER-1:0]   j;
   logic [LOG_MAX_ITERS-1:0]            i;
   logic [CW-1:0]                       in_flight;
   logic [CW-1:0]                       fifo_count;
   logic [PW-1:0]                       rd_ptr, wr_ptr;
   logic [DATA_WIDTH-1:0]               fifo_mem [FIFO_DEPTH];

   logic          issue, push, pop, last_i, last_j, can_issue;
   logic [CW:0]   occupancy;

   // Returns are only accepted while a transfer owns outstanding requests.
   assign push      = valid_in && (state != IDLE) && (in_flight != '0);
   assign pop       = (fifo_count != '0) && avail_in;
   assign occupancy = {1'b0, fifo_count} + {1'b0, in_flight} - {{CW{1'b0}}, pop};
   assign can_issue = (occupancy < DEPTH_W);
   assign last_j    = (j == cfg_reads - LOG_MAX_READS_PER_ITER'(1));
   assign last_i    = (i == cfg_iters - LOG_MAX_ITERS'(1));

   assign valid_out = (fifo_count != '0);
   assign data_out  = valid_out ? fifo_mem[rd_ptr] : '0;
   assign busy      = (state == RUN) || (state == DRAIN);
   assign done      = (state == FINISH);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      unique case (state)
         IDLE: begin
            // An empty pattern passes through DRAIN, which exits at once.
            if (configure)
               state_next = (num_iters == '0 || num_reads_per_iter == '0) ? DRAIN : RUN;
         end
         RUN: begin
            if (can_issue) begin
               issue = 1'b1;
               if (last_i && last_j) state_next = DRAIN;
            end
         end
         DRAIN: begin
            // Leave on the edge of the final pop so done follows it by exactly one cycle.
            if (in_flight == '0 &&
                (fifo_count == '0 || (fifo_count == CW'(1) && pop)))
               state_next = FINISH;
         end
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_iters   <= '0;
         cfg_reads   <= '0;
         cfg_stride  <= '0;
         iter_base   <= '0;
         j           <= '0;
         i           <= '0;
         request     <= 1'b0;
         address_out <= '0;
         in_flight   <= '0;
      end else begin
         request <= issue;
         if (state == IDLE && configure) begin
            cfg_iters  <= num_iters;
            cfg_reads  <= num_reads_per_iter;
            cfg_stride <= iter_stride;
            iter_base  <= base_address;
            j          <= '0;
            i          <= '0;
         end else if (issue) begin
            address_out <= iter_base + LOG_MAX_ADDRESS'(j);
            if (last_j) begin
               j         <= '0;
               i         <= i + LOG_MAX_ITERS'(1);
               iter_base <= iter_base + cfg_stride;
            end else begin
               j <= j + LOG_MAX_READS_PER_ITER'(1);
            end
         end
         unique case ({issue, push})
            2'b10:   in_flight <= in_flight + CW'(1);
            2'b01:   in_flight <= in_flight - CW'(1);
            default: in_flight <= in_flight;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // NOTE: storage is not reset; fifo_count gates every read, so stale contents are never visible.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= data_in;
   end

endmodule

// File: tb/tb_read_strided.sv
// Directed bench for read_strided: a latency-1 ROM model feeds the engine, and each
// scenario task compares addresses, ordered data, stalls, done timing and reset behaviour.
module tb_read_strided;

   localparam int DW = 8, LI = 8, LR = 16, LA = 12, DEPTH = 4;

   logic          clk = 1'b0, rst = 1'b0, configure = 1'b0;
   logic [LI-1:0] num_iters = '0;
   logic [LR-1:0] num_reads_per_iter = '0;
   logic [LA-1:0] base_address = '0, iter_stride = '0;
   logic [LA-1:0] address_out;
   logic          request, valid_in = 1'b0, avail_in = 1'b0, valid_out, busy, done;
   logic [DW-1:0] data_in = '0, data_out;

   int checks = 0;
   int errors = 0;

   read_strided #(
      .DATA_WIDTH(DW), .LOG_MAX_ITERS(LI), .LOG_MAX_READS_PER_ITER(LR),
      .LOG_MAX_ADDRESS(LA), .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
      .num_reads_per_iter(num_reads_per_iter), .base_address(base_address),
      .iter_stride(iter_stride), .address_out(address_out), .request(request),
      .valid_in(valid_in), .data_in(data_in), .avail_in(avail_in),
      .valid_out(valid_out), .data_out(data_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Preloaded MEM contents as a function of address; unique low byte within each pattern.
   function automatic logic [DW-1:0] mem_word(input logic [LA-1:0] a);
      return a[7:0] ^ {a[11:8], 4'h3};
   endfunction

   // Fixed latency-1 memory port.
   always @(posedge clk) begin
      valid_in <= request;
      data_in  <= mem_word(address_out);
   end

   task automatic run_pattern(input string name, input logic [LA-1:0] base, input int iters,
                              input int reads, input logic [LA-1:0] stride, input int bp_mode,
                              input int stop_after, input bit mid_cfg,
                              output int req_span, output int pop_span);
      logic [LA-1:0] exp_addr[$];
      logic [LA-1:0] itb;
      logic [DW-1:0] prev_data = '0;
      bit prev_stall = 0;
      int total, issued = 0, popped = 0, done_cnt = 0, done_cycle = -1;
      int first_req = -1, last_req = -1, first_pop = -1, last_pop = -1;
      itb = base;
      for (int it = 0; it < iters; it++) begin
         for (int jj = 0; jj < reads; jj++) exp_addr.push_back(itb + LA'(jj));
         itb = itb + stride;
      end
      total = exp_addr.size();
      req_span = 0;
      pop_span = 0;
      @(negedge clk);
      configure = 1'b1;
      num_iters = LI'(iters);
      num_reads_per_iter = LR'(reads);
      base_address = base;
      iter_stride = stride;
      for (int cyc = 1; cyc <= 3000; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            configure = 1'b0;
            num_iters = 8'hA5;
            num_reads_per_iter = 16'h0BAD;
            base_address = 12'h777;
            iter_stride = 12'h123;
         end
         if (mid_cfg) begin
            configure = (cyc == 8);
            num_iters = 8'd1;
            num_reads_per_iter = 16'd1;
            base_address = 12'h000;
         end
         avail_in = (bp_mode == 0) ? 1'b1 : (cyc <= 20) ? 1'b0 : ((cyc % 2) == 0);
         if (request) begin
            checks++;
            if (issued >= total) begin
               errors++;
               $display("FAIL %s extra_request: got request %0d at addr %0d, required %0d requests",
                        name, issued + 1, address_out, total);
            end else if (address_out !== exp_addr[issued]) begin
               errors++;
               $display("FAIL %s addr[%0d]: got %0d required %0d", name, issued, address_out,
                        exp_addr[issued]);
            end
            if (first_req < 0) first_req = cyc;
            last_req = cyc;
            issued++;
         end
         checks++;
         if (issued - popped > DEPTH) begin
            errors++;
            $display("FAIL %s occupancy: got %0d outstanding, required <= %0d", name,
                     issued - popped, DEPTH);
         end
         if (bp_mode == 1 && cyc == 20) begin
            checks++;
            if (issued != DEPTH) begin
               errors++;
               $display("FAIL %s stall_requests: got %0d issued, required %0d", name, issued, DEPTH);
            end
         end
         if (valid_out) begin
            if (prev_stall) begin
               checks++;
               if (data_out !== prev_data) begin
                  errors++;
                  $display("FAIL %s stable_data: got %0h required %0h", name, data_out, prev_data);
               end
            end
            if (avail_in) begin
               checks++;
               if (popped >= total) begin
                  errors++;
                  $display("FAIL %s extra_output: got output %0d, required %0d outputs", name,
                           popped + 1, total);
               end else if (data_out !== mem_word(exp_addr[popped])) begin
                  errors++;
                  $display("FAIL %s data[%0d]: got %0h required %0h", name, popped, data_out,
                           mem_word(exp_addr[popped]));
               end
               if (first_pop < 0) first_pop = cyc;
               last_pop = cyc;
               popped++;
            end
         end
         prev_stall = valid_out && !avail_in;
         prev_data  = data_out;
         if (stop_after > 0 && popped == stop_after) return;
         if (done) begin
            done_cnt++;
            if (done_cycle < 0) done_cycle = cyc;
         end
         if (done_cycle >= 0 && cyc == done_cycle + 1) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
               errors++;
               $display("FAIL %s after_done: got busy=%0b done=%0b, required 0 0", name, busy, done);
            end
            break;
         end
      end
      avail_in = 1'b0;
      checks++;
      if (done_cnt != 1) begin
         errors++;
         $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt);
      end
      checks++;
      if (issued != total || popped != total) begin
         errors++;
         $display("FAIL %s counts: got %0d requests %0d outputs, required %0d", name, issued,
                  popped, total);
      end
      checks++;
      if (done_cycle != ((total == 0) ? 2 : last_pop + 1)) begin
         errors++;
         $display("FAIL %s done_timing: got cycle %0d required %0d", name, done_cycle,
                  (total == 0) ? 2 : last_pop + 1);
      end
      if (first_req >= 0) req_span = last_req - first_req + 1;
      if (first_pop >= 0) pop_span = last_pop - first_pop + 1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (request !== 1'b0 || valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          address_out !== '0 || data_out !== '0) begin
         errors++;
         $display("FAIL reset_state: got req=%0b vo=%0b busy=%0b done=%0b addr=%0d data=%0h, required all 0",
                  request, valid_out, busy, done, address_out, data_out);
      end
      rst = 1'b1;
   endtask

   task automatic test_contiguous();
      int rs, ps;
      run_pattern("contig", 12'd32, 4, 16, 12'd16, 0, 0, 0, rs, ps);
      checks++;
      if (rs != 64 || ps != 64) begin
         errors++;
         $display("FAIL contig_throughput: got req span %0d out span %0d, required 64 64", rs, ps);
      end
   endtask

   task automatic test_stride();
      int rs, ps;
      run_pattern("stride64", 12'd32, 4, 16, 12'd64, 0, 0, 0, rs, ps);
   endtask

   task automatic test_wrap();
      int rs, ps;
      run_pattern("wrap", 12'd4090, 1, 8, 12'd0, 0, 0, 0, rs, ps);
   endtask

   task automatic test_backpressure();
      int rs, ps;
      run_pattern("backpressure", 12'd100, 3, 10, 12'd200, 1, 0, 0, rs, ps);
   endtask

   task automatic test_zero_length();
      int rs, ps;
      run_pattern("zero_iters", 12'd10, 0, 5, 12'd1, 0, 0, 0, rs, ps);
      run_pattern("zero_reads", 12'd10, 3, 0, 12'd1, 0, 0, 0, rs, ps);
      checks++;
      if (rs != 0 || ps != 0) begin
         errors++;
         $display("FAIL zero_activity: got req span %0d out span %0d, required 0 0", rs, ps);
      end
   endtask

   task automatic test_config_ignored();
      int rs, ps;
      run_pattern("cfg_in_run", 12'd32, 2, 5, 12'd100, 0, 0, 1, rs, ps);
   endtask

   task automatic test_reset_mid_run();
      int rs, ps;
      run_pattern("pre_reset", 12'd32, 4, 16, 12'd16, 0, 10, 0, rs, ps);
      rst = 1'b0;
      #1;
      checks++;
      if (request !== 1'b0 || valid_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          address_out !== '0 || data_out !== '0) begin
         errors++;
         $display("FAIL mid_reset: got req=%0b vo=%0b busy=%0b done=%0b addr=%0d data=%0h, required all 0",
                  request, valid_out, busy, done, address_out, data_out);
      end
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got vo=%0b busy=%0b, required 0 0", valid_out, busy);
      end
      run_pattern("after_reset", 12'd32, 4, 16, 12'd16, 0, 0, 0, rs, ps);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_contiguous();
      test_stride();
      test_wrap();
      test_backpressure();
      test_zero_length();
      test_config_ignored();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
